// File: rtl/irq_plic_lite_pkg.sv
// Shared sizing, register map and decode helper for the lightweight PLIC.
// Only the low address byte selects a register; the base address is informational.
package irq_plic_lite_pkg;

  localparam int N_SRC  = 8;
  localparam int N_HART = 2;
  localparam int PRIO_W = 3;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = $clog2(N_SRC);
  localparam int HART_W = $clog2(N_HART);

  localparam logic [ADDR_W-1:0] PLIC_BASE = 32'h0C00_0000;

  localparam logic [7:0] OFF_PENDING = 8'h00;
  localparam logic [7:0] OFF_PRIO    = 8'h20;
  localparam logic [7:0] OFF_ENABLE  = 8'h40;
  localparam logic [7:0] OFF_THRESH  = 8'h48;
  localparam logic [7:0] OFF_CLAIM   = 8'h50;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PENDING,
    REG_PRIO,
    REG_ENABLE,
    REG_THRESH,
    REG_CLAIM
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] idx;
  } reg_sel_t;

  // Unaligned offsets fall through to REG_NONE so they read as zero.
  function automatic reg_sel_t decode_offset(input logic [7:0] off);
    reg_sel_t sel;
    sel.kind = REG_NONE;
    sel.idx  = 3'd0;
    if (off[1:0] == 2'b00) begin
      if (off == OFF_PENDING) begin
        sel.kind = REG_PENDING;
      end else if (off[7:5] == OFF_PRIO[7:5]) begin
        sel.kind = REG_PRIO;
        sel.idx  = off[4:2];
      end else if (off[7:3] == OFF_ENABLE[7:3]) begin
        sel.kind = REG_ENABLE;
        sel.idx  = {2'b00, off[2]};
      end else if (off[7:3] == OFF_THRESH[7:3]) begin
        sel.kind = REG_THRESH;
        sel.idx  = {2'b00, off[2]};
      end else if (off[7:3] == OFF_CLAIM[7:3]) begin
        sel.kind = REG_CLAIM;
        sel.idx  = {2'b00, off[2]};
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source level gateway: latches a request once and holds it off until
// the handler has claimed and completed it.
module irq_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  // Claim wins over a new level request; complete only frees the source, so
  // a still-high input re-pends one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      if (claim) begin
        pending <= 1'b0;
      end else if (src && !pending && !in_service) begin
        pending <= 1'b1;
      end

      if (claim) begin
        in_service <= 1'b1;
      end else if (complete) begin
        in_service <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_plic_lite.sv
// Small platform-level interrupt controller: per-source gateways, per-hart
// priority/threshold arbitration and a single-cycle MMIO register port.
module irq_plic_lite
  import irq_plic_lite_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [N_HART-1:0] ext_irq
);

  logic [PRIO_W-1:0] prio      [N_SRC];
  logic [N_SRC-1:0]  enable    [N_HART];
  logic [PRIO_W-1:0] thresh    [N_HART];
  logic [ID_W-1:0]   best      [N_HART];
  logic [PRIO_W-1:0] best_prio [N_HART];

  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  in_service;
  logic [N_SRC-1:0]  claim_vec;
  logic [N_SRC-1:0]  complete_vec;
  logic [XLEN-1:0]   rd_data;
  logic [HART_W-1:0] hart;
  reg_sel_t          sel;
  logic              wr_en;
  logic              rd_en;
  logic              unused_bits;

  assign sel   = decode_offset(req_addr[7:0]);
  assign hart  = sel.idx[HART_W-1:0];
  assign wr_en = req_valid & req_we;
  assign rd_en = req_valid & ~req_we;

  assign unused_bits = ^{req_addr[ADDR_W-1:8], irq_src[0], claim_vec[0], complete_vec[0]};

  assign pending[0]    = 1'b0;
  assign in_service[0] = 1'b0;

  for (genvar i = 1; i < N_SRC; i++) begin : g_gw
    irq_gateway u_gw (
      .clk        (clk),
      .rst_n      (rst_n),
      .src        (irq_src[i]),
      .claim      (claim_vec[i]),
      .complete   (complete_vec[i]),
      .pending    (pending[i]),
      .in_service (in_service[i])
    );
  end

  // Seeding the running maximum with the threshold makes "greater than
  // threshold" and "highest priority" one strict compare; strictness keeps
  // the lowest ID on ties.
  always_comb begin
    for (int h = 0; h < N_HART; h++) begin
      best[h]      = '0;
      best_prio[h] = thresh[h];
      for (int i = 1; i < N_SRC; i++) begin
        if (pending[i] && enable[h][i] && (prio[i] > best_prio[h])) begin
          best[h]      = ID_W'(i);
          best_prio[h] = prio[i];
        end
      end
    end
  end

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    if (rd_en && (sel.kind == REG_CLAIM) && (best[hart] != '0)) begin
      claim_vec[best[hart]] = 1'b1;
    end
    if (wr_en && (sel.kind == REG_CLAIM) && (req_wdata != '0) &&
        (req_wdata < XLEN'(N_SRC)) && in_service[req_wdata[ID_W-1:0]]) begin
      complete_vec[req_wdata[ID_W-1:0]] = 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (sel.kind)
      REG_PENDING: rd_data[N_SRC-1:0]  = pending;
      REG_PRIO:    rd_data[PRIO_W-1:0] = prio[sel.idx];
      REG_ENABLE:  rd_data[N_SRC-1:0]  = enable[hart];
      REG_THRESH:  rd_data[PRIO_W-1:0] = thresh[hart];
      REG_CLAIM:   rd_data[ID_W-1:0]   = best[hart];
      default:     rd_data = '0;
    endcase
  end

  // PRIO[0] belongs to the reserved "none" ID and stays zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
      for (int h = 0; h < N_HART; h++) begin
        enable[h] <= '0;
        thresh[h] <= '0;
      end
    end else if (wr_en) begin
      case (sel.kind)
        REG_PRIO:   if (sel.idx != '0) prio[sel.idx] <= req_wdata[PRIO_W-1:0];
        REG_ENABLE: enable[hart] <= req_wdata[N_SRC-1:0] & ~N_SRC'(1);
        REG_THRESH: thresh[hart] <= req_wdata[PRIO_W-1:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_ready <= 1'b0;
      rsp_rdata <= '0;
      ext_irq   <= '0;
    end else begin
      rsp_ready <= req_valid;
      rsp_rdata <= rd_en ? rd_data : '0;
      for (int h = 0; h < N_HART; h++) ext_irq[h] <= (best[h] != '0);
    end
  end

endmodule

// File: tb/tb_irq_plic_lite.sv
// Directed self-checking bench for irq_plic_lite: register map, gateway,
// arbitration, threshold, level re-trigger, two harts and reset.
module tb_irq_plic_lite;
  import irq_plic_lite_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_SRC-1:0]  irq_src;
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic [N_HART-1:0] ext_irq;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          flag;
  logic [31:0] rd;

  irq_plic_lite dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ext_irq   (ext_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIrq(input string tag, input logic [1:0] expected);
    checkOutput(tag, {30'b0, ext_irq}, {30'b0, expected});
  endtask

  // Called at a falling edge; returns at the next falling edge with the response sampled.
  task automatic applyStimulus(input logic we, input logic [7:0] off, input logic [31:0] wdata,
                               output logic [31:0] rdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = PLIC_BASE | ADDR_W'(off);
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = '0;
    checkOutput("rsp_ready", {31'b0, rsp_ready}, 32'd1);
    rdata = rsp_rdata;
  endtask

  task automatic writeReg(input logic [7:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(1'b1, off, data, dummy);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] off, input logic [31:0] expected);
    logic [31:0] value;
    applyStimulus(1'b0, off, 32'd0, value);
    checkOutput(tag, value, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    irq_src   = '0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    flag      = 0;
    idle(2);
    rst_n = 1'b1;

    checkOutput("reset rsp_ready", {31'b0, rsp_ready}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkIrq("reset ext_irq", 2'b00);
    readCheck("reset pending", 8'h00, 32'd0);

    // All priorities zero: nothing may interrupt, but pending still latches.
    irq_src = 8'hFF;
    idle(3);
    checkIrq("prio0 no irq", 2'b00);
    readCheck("pending bit0 ignored", 8'h00, 32'h0000_00FE);
    irq_src = 8'h00;
    resetDut();
    readCheck("pending after reset", 8'h00, 32'd0);

    // Basic claim/complete
    writeReg(8'h24, 32'd1);
    writeReg(8'h40, 32'h02);
    writeReg(8'h48, 32'd0);
    readCheck("prio1 readback", 8'h24, 32'd1);
    irq_src = 8'h02;
    idle(1);
    irq_src = 8'h00;
    checkIrq("irq latency 1clk", 2'b00);
    idle(1);
    checkIrq("irq latency 2clk", 2'b01);
    readCheck("claim id1", 8'h50, 32'd1);
    idle(1);
    checkIrq("irq drop after claim", 2'b00);
    readCheck("pending cleared by claim", 8'h00, 32'd0);
    writeReg(8'h50, 32'd1);
    idle(2);
    checkIrq("irq after complete", 2'b00);
    readCheck("claim empty", 8'h50, 32'd0);

    // Register map edges
    writeReg(8'h3C, 32'hFFFF_FFFF);
    readCheck("prio7 width", 8'h3C, 32'd7);
    writeReg(8'h3C, 32'd0);
    writeReg(8'h20, 32'd5);
    readCheck("prio0 hardwired", 8'h20, 32'd0);
    readCheck("unmapped 0x60", 8'h60, 32'd0);
    readCheck("unaligned 0x25", 8'h25, 32'd0);
    writeReg(8'h44, 32'hFFFF_FFFF);
    readCheck("enable1 bit0 forced", 8'h44, 32'h0000_00FE);
    idle(1);
    checkOutput("idle rsp_ready", {31'b0, rsp_ready}, 32'd0);
    checkOutput("idle rsp_rdata", rsp_rdata, 32'd0);
    writeReg(8'h44, 32'd0);

    // Arbitration: highest priority first, ties to lowest ID
    writeReg(8'h28, 32'd3);
    writeReg(8'h34, 32'd3);
    writeReg(8'h2C, 32'd5);
    writeReg(8'h40, 32'h2F);
    readCheck("enable0 readback", 8'h40, 32'h2E);
    irq_src = 8'h2C;
    idle(1);
    irq_src = 8'h00;
    idle(1);
    readCheck("pending 2,3,5", 8'h00, 32'h2C);
    checkIrq("arb irq", 2'b01);
    readCheck("arb claim 3", 8'h50, 32'd3);
    readCheck("arb claim 2", 8'h50, 32'd2);
    readCheck("arb claim 5", 8'h50, 32'd5);
    readCheck("arb claim none", 8'h50, 32'd0);
    writeReg(8'h50, 32'd3);
    writeReg(8'h50, 32'd2);
    writeReg(8'h50, 32'd5);

    // Threshold
    writeReg(8'h30, 32'd2);
    writeReg(8'h40, 32'h10);
    writeReg(8'h48, 32'd2);
    irq_src = 8'h10;
    idle(3);
    checkIrq("thresh blocks", 2'b00);
    writeReg(8'h48, 32'd1);
    checkIrq("thresh 1clk after write", 2'b00);
    idle(1);
    checkIrq("thresh 2clk after write", 2'b01);
    irq_src = 8'h00;
    readCheck("thresh claim 4", 8'h50, 32'd4);
    writeReg(8'h50, 32'd4);

    // Level re-trigger
    writeReg(8'h48, 32'd0);
    writeReg(8'h40, 32'h02);
    irq_src = 8'h02;
    idle(2);
    checkIrq("level irq", 2'b01);
    readCheck("level claim 1", 8'h50, 32'd1);
    readCheck("level second claim", 8'h50, 32'd0);
    checkIrq("level in service", 2'b00);
    writeReg(8'h50, 32'd1);
    checkIrq("level complete +1", 2'b00);
    idle(1);
    checkIrq("level complete +2", 2'b00);
    idle(1);
    checkIrq("level reassert", 2'b01);
    readCheck("level reclaim 1", 8'h50, 32'd1);
    irq_src = 8'h00;
    writeReg(8'h50, 32'd1);

    // Two harts
    writeReg(8'h40, 32'h40);
    writeReg(8'h44, 32'h40);
    writeReg(8'h38, 32'd4);
    irq_src = 8'h40;
    idle(1);
    irq_src = 8'h00;
    idle(1);
    checkIrq("two harts both", 2'b11);
    readCheck("hart1 claim 6", 8'h54, 32'd6);
    idle(1);
    checkIrq("two harts drop", 2'b00);
    readCheck("hart0 claim none", 8'h50, 32'd0);
    writeReg(8'h50, 32'd7);
    idle(2);
    checkIrq("complete 7 ignored", 2'b00);
    irq_src = 8'h40;
    idle(2);
    readCheck("no repend in service", 8'h00, 32'd0);
    irq_src = 8'h00;
    writeReg(8'h50, 32'd6);
    irq_src = 8'h40;
    idle(1);
    irq_src = 8'h00;
    idle(1);
    checkIrq("src6 free again", 2'b11);
    readCheck("hart0 claim 6", 8'h50, 32'd6);
    writeReg(8'h50, 32'd6);

    // Reset mid-service, with a request in flight during reset
    writeReg(8'h40, 32'h02);
    writeReg(8'h4C, 32'd5);
    irq_src = 8'h02;
    idle(1);
    irq_src = 8'h00;
    idle(1);
    checkIrq("pre-reset irq", 2'b01);
    readCheck("pre-reset claim 1", 8'h50, 32'd1);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = PLIC_BASE | ADDR_W'(8'h24);
    idle(1);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    checkOutput("reset drops request", {31'b0, rsp_ready}, 32'd0);
    checkOutput("reset rdata zero", rsp_rdata, 32'd0);
    checkIrq("reset irq zero", 2'b00);
    readCheck("reset prio1", 8'h24, 32'd0);
    readCheck("reset enable0", 8'h40, 32'd0);
    readCheck("reset thresh1", 8'h4C, 32'd0);
    readCheck("reset pending2", 8'h00, 32'd0);

    // DMA-done end to end: source 1 must be claimable again after reset
    writeReg(8'h24, 32'd1);
    writeReg(8'h40, 32'h02);
    irq_src = 8'h02;
    idle(1);
    irq_src = 8'h00;
    idle(1);
    checkIrq("dma irq", 2'b01);
    if (ext_irq[0]) begin
      applyStimulus(1'b0, 8'h50, 32'd0, rd);
      if (rd == 32'd1) begin
        writeReg(8'h50, rd);
        flag = 1;
      end
    end
    checkOutput("dma flag", flag, 32'd1);
    idle(2);
    checkIrq("dma irq cleared", 2'b00);
    readCheck("dma claim none", 8'h50, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
